sbox_share_sched: RTL

//  Time-multiplexes a small bank of byte S-box lookups between two requesters:
//  the round datapath (SubBytes on a 128-bit state) and key expansion (SubWord
//  on a 32-bit word). It replaces 20 parallel S-boxes with NUM_LANES lanes.
//  The block sits between the round controller / key scheduler and the sbox bank.

---
 rtl/aes_pkg.sv | 38 +++
 rtl/sbox_share_sched_lane_bank.sv | 16 +
 rtl/sbox_share_sched.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES widths, scheduler FSM encoding and byte S-box table
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_WORD_W  = 32;
  localparam int AES_BYTES   = 16;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } sched_state_e;

  // AES forward S-box, indexed by the input byte
  localparam logic [7:0] SBOX_TABLE [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // purely combinational byte substitution used by every lane
  function automatic logic [7:0] aes_sbox(input logic [7:0] b);
    return SBOX_TABLE[b];
  endfunction

endpackage

// File: rtl/sbox_share_sched_lane_bank.sv
// rtl/sbox_share_sched_lane_bank.sv - NUM_LANES parallel combinational byte S-boxes on a flat bus
module sbox_lane_bank
  import aes_pkg::*;
#(
  parameter int NUM_LANES = 4
) (
  input  logic [NUM_LANES*8-1:0] lane_in,
  output logic [NUM_LANES*8-1:0] lane_out
);

  // each lane substitutes its own byte; lanes are independent of ordering
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign lane_out[i*8 +: 8] = aes_sbox(lane_in[i*8 +: 8]);
  end

endmodule

// File: rtl/sbox_share_sched.sv
// rtl/sbox_share_sched.sv - shares a small S-box lane bank between SubBytes and SubWord requesters
module sbox_share_sched
  import aes_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter bit KEY_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ks_req_valid,
  output logic                   ks_req_ready,
  input  logic [AES_WORD_W-1:0]  ks_word_in,
  output logic                   ks_rsp_valid,
  output logic [AES_WORD_W-1:0]  ks_word_out,
  input  logic                   st_req_valid,
  output logic                   st_req_ready,
  input  logic [AES_STATE_W-1:0] st_in,
  output logic                   st_rsp_valid,
  output logic [AES_STATE_W-1:0] st_out,
  output logic                   busy
);

  localparam int SLOTS  = AES_BYTES / NUM_LANES;
  localparam int CIDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int LANE_W = NUM_LANES * 8;
  localparam logic [CIDX_W-1:0] CIDX_LAST = CIDX_W'(SLOTS - 1);

  sched_state_e           state_q, state_d;
  logic [CIDX_W-1:0]      cidx_q, cidx_d;
  logic                   flag_q, flag_d;
  logic [AES_STATE_W-1:0] buf_q, buf_d;
  logic [AES_STATE_W-1:0] st_out_q, st_out_d;
  logic [AES_WORD_W-1:0]  ks_word_out_q, ks_word_out_d;
  logic                   ks_rsp_valid_q, ks_rsp_valid_d;
  logic                   st_rsp_valid_q, st_rsp_valid_d;

  logic                   key_slot, st_slot, st_accept, last_slot;
  logic [LANE_W-1:0]      lane_in, lane_out;

  // chunk 0 holds bytes 0..NUM_LANES-1, which sit in the most significant bits
  logic [0:SLOTS-1][LANE_W-1:0] buf_chunks;
  logic [0:SLOTS-1][LANE_W-1:0] out_chunks;

  assign buf_chunks = buf_q;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: a job starts on acceptance and ends on its last state slot
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (st_accept) state_d = S_RUN;
      S_RUN:   if (st_slot && last_slot) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs: handshakes and slot ownership; the flag forces a state slot after each stolen one
  always_comb begin
    st_req_ready = (state_q == S_IDLE);
    ks_req_ready = 1'b1;
    if (state_q == S_RUN) ks_req_ready = KEY_FIRST ? ~flag_q : 1'b0;
    key_slot  = ks_req_valid & ks_req_ready;
    st_slot   = (state_q == S_RUN) & ~key_slot;
    st_accept = st_req_valid & st_req_ready;
    last_slot = (cidx_q == CIDX_LAST);
    busy      = (state_q == S_RUN);
  end

  // lane mux: the key word occupies the top four lanes, remaining lanes idle at zero
  always_comb begin
    lane_in = buf_chunks[cidx_q];
    if (key_slot) begin
      lane_in = '0;
      lane_in[LANE_W-1 -: AES_WORD_W] = ks_word_in;
    end
  end

  sbox_lane_bank #(
    .NUM_LANES(NUM_LANES)
  ) u_bank (
    .lane_in (lane_in),
    .lane_out(lane_out)
  );

  // datapath next values: capture, chunk write-back, counter and fairness flag
  always_comb begin
    buf_d          = buf_q;
    cidx_d         = cidx_q;
    flag_d         = flag_q;
    ks_word_out_d  = ks_word_out_q;
    ks_rsp_valid_d = 1'b0;
    st_rsp_valid_d = 1'b0;
    out_chunks     = st_out_q;
    if (key_slot) begin
      ks_word_out_d  = lane_out[LANE_W-1 -: AES_WORD_W];
      ks_rsp_valid_d = 1'b1;
      if (state_q == S_RUN) flag_d = 1'b1;
    end
    if (st_accept) begin
      buf_d  = st_in;
      cidx_d = '0;
    end
    if (st_slot) begin
      out_chunks[cidx_q] = lane_out;
      flag_d             = 1'b0;
      if (last_slot) begin
        st_rsp_valid_d = 1'b1;
        cidx_d         = '0;
      end else begin
        cidx_d = cidx_q + 1'b1;
      end
    end
    st_out_d = out_chunks;
  end

  // datapath and output registers; reset drops any job in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cidx_q         <= '0;
      flag_q         <= 1'b0;
      buf_q          <= '0;
      st_out_q       <= '0;
      ks_word_out_q  <= '0;
      ks_rsp_valid_q <= 1'b0;
      st_rsp_valid_q <= 1'b0;
    end else begin
      cidx_q         <= cidx_d;
      flag_q         <= flag_d;
      buf_q          <= buf_d;
      st_out_q       <= st_out_d;
      ks_word_out_q  <= ks_word_out_d;
      ks_rsp_valid_q <= ks_rsp_valid_d;
      st_rsp_valid_q <= st_rsp_valid_d;
    end
  end

  assign ks_rsp_valid = ks_rsp_valid_q;
  assign ks_word_out  = ks_word_out_q;
  assign st_rsp_valid = st_rsp_valid_q;
  assign st_out       = st_out_q;

endmodule
